// File: rtl/hs32_regfile_if.sv
// hs32_regfile_if
// Bundles the execute-stage write port, the two decode-stage read ports,
// the mode select and the busy flag of the hs32 register file.
//   mode_i                : 0 = user, 1 = supervisor
//   wp_addr_i/wp_data_i   : write address / data
//   wp_we1_i              : write into the bank selected by mode_i
//   wp_we2_i              : write into the user bank regardless of mode
//   rp1_addr_i/rp1_data_o : read port 1 (data one cycle after address)
//   rp2_addr_i/rp2_data_o : read port 2 (data one cycle after address)
//   busy_o                : high while the storage is being scrubbed
// master = the core side driving requests, slave = the register file.
interface hs32_regfile_if;
    logic        mode_i;
    logic [3:0]  wp_addr_i;
    logic [31:0] wp_data_i;
    logic        wp_we1_i;
    logic        wp_we2_i;
    logic [3:0]  rp1_addr_i;
    logic [31:0] rp1_data_o;
    logic [3:0]  rp2_addr_i;
    logic [31:0] rp2_data_o;
    logic        busy_o;

    modport master (
        output mode_i, wp_addr_i, wp_data_i, wp_we1_i, wp_we2_i,
        output rp1_addr_i, rp2_addr_i,
        input  rp1_data_o, rp2_data_o, busy_o
    );

    modport slave (
        input  mode_i, wp_addr_i, wp_data_i, wp_we1_i, wp_we2_i,
        input  rp1_addr_i, rp2_addr_i,
        output rp1_data_o, rp2_data_o, busy_o
    );
endinterface

// File: rtl/hs32_regfile.sv
// hs32_regfile
// Architectural register file of the hs32 core: 16 x 32-bit registers,
// r12-r15 banked between user and supervisor mode (20 physical entries).
// One write per cycle, two registered reads per cycle with write-first
// bypass. The storage array has no reset; after reset a scrub sequencer
// writes zero to every entry while busy_o is high.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : hs32_regfile_if.slave (write port, two read ports, mode, busy)
module hs32_regfile (
    input  logic              clk,
    input  logic              reset,
    hs32_regfile_if.slave     bus
);
    localparam int unsigned NUM_ENTRIES = 20;
    localparam logic [4:0]  LAST_ENTRY  = 5'd19;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic        busy_reg;

    logic [31:0] mem [0:NUM_ENTRIES-1];

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;

    // Architectural address + bank -> physical entry. Only r12-r15 are
    // banked; supervisor copies live in entries 16-19.
    function automatic logic [4:0] phys_idx(input logic [3:0] addr, input logic sup);
        if (sup && (addr >= 4'd12))
            return {1'b0, addr} + 5'd4;
        else
            return {1'b0, addr};
    endfunction

    // Scrub sequencer; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SCRUB;
            cnt_reg   <= 5'd0;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                SCRUB: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_ENTRY) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end
                end
                READY: begin
                    state_reg <= READY;
                end
                default: begin
                    state_reg <= SCRUB;
                    cnt_reg   <= 5'd0;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    // Single physical write port. Scrub owns it completely; otherwise we1
    // takes priority and a simultaneous we2 is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = 5'd0;
        wr_data = 32'd0;
        if (!reset) begin
            if (state_reg == SCRUB) begin
                wr_en   = 1'b1;
                wr_idx  = cnt_reg;
                wr_data = 32'd0;
            end else if (bus.wp_we1_i) begin
                wr_en   = 1'b1;
                wr_idx  = phys_idx(bus.wp_addr_i, bus.mode_i);
                wr_data = bus.wp_data_i;
            end else if (bus.wp_we2_i) begin
                wr_en   = 1'b1;
                wr_idx  = phys_idx(bus.wp_addr_i, 1'b0);
                wr_data = bus.wp_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    logic [3:0] rd_addr [2];
    assign rd_addr[0] = bus.rp1_addr_i;
    assign rd_addr[1] = bus.rp2_addr_i;

    // Two identical read ports. Both use the current mode for bank
    // selection; a write to the same physical entry at the same edge is
    // forwarded so the reader sees the new value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : rd_port
            logic [4:0]  rd_idx;
            logic [31:0] data_reg;

            assign rd_idx = phys_idx(rd_addr[gi], bus.mode_i);

            always_ff @(posedge clk) begin
                if (reset || (state_reg == SCRUB))
                    data_reg <= 32'd0;
                else if (wr_en && (wr_idx == rd_idx))
                    data_reg <= wr_data;
                else
                    data_reg <= mem[rd_idx];
            end
        end
    endgenerate

    assign bus.rp1_data_o = rd_port[0].data_reg;
    assign bus.rp2_data_o = rd_port[1].data_reg;
    assign bus.busy_o     = busy_reg;
endmodule

// File: tb/tb_hs32_regfile.sv
// tb_hs32_regfile
// Directed stimulus for hs32_regfile. Expectations are queued when the
// inputs for an edge are driven and compared just after that edge.
module tb_hs32_regfile;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hs32_regfile_if bus ();

    hs32_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    string       tag_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];

    // sel: 0 = rp1_data_o, 1 = rp2_data_o, 2 = busy_o
    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic expect_reads(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                                input logic busy);
        expect_val({tag, "_rp1"}, 0, v1);
        expect_val({tag, "_rp2"}, 1, v2);
        expect_val({tag, "_busy"}, 2, {31'd0, busy});
    endtask

    task automatic drive(input logic mode, input logic [3:0] waddr, input logic [31:0] wdata,
                         input logic we1, input logic we2,
                         input logic [3:0] ra1, input logic [3:0] ra2);
        bus.mode_i     = mode;
        bus.wp_addr_i  = waddr;
        bus.wp_data_i  = wdata;
        bus.wp_we1_i   = we1;
        bus.wp_we2_i   = we2;
        bus.rp1_addr_i = ra1;
        bus.rp2_addr_i = ra2;
    endtask

    task automatic tick();
        string       tag;
        int          sel;
        logic [31:0] ev;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front();
            sel = sel_q.pop_front();
            ev  = exp_q.pop_front();
            case (sel)
                0:       obs = bus.rp1_data_o;
                1:       obs = bus.rp2_data_o;
                default: obs = {31'd0, bus.busy_o};
            endcase
            checks++;
            assert (obs === ev) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, ev);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- scrub after reset, we1 r3 held throughout ----
        reset = 1'b1;
        drive(1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3, 4'd3);
        for (int k = 0; k < 2; k++) begin
            expect_reads($sformatf("rst%0d", k), 32'd0, 32'd0, 1'b1);
            tick();
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            expect_reads($sformatf("scrub_a%0d", k), 32'd0, 32'd0, (k < 20));
            tick();
        end
        drive(1'b0, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd3, 4'd3);
        expect_reads("r3_after_scrub", 32'd0, 32'd0, 1'b0);
        tick();
        $display("scrub with held r3 write done");

        // ---- reset, then pulse reset at scrub cycle 10, write noise ----
        reset = 1'b1;
        expect_reads("rst_b", 32'd0, 32'd0, 1'b1);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive(k[0], 4'(1 + (k % 11)), 32'h5A000000 | k, ~k[0], k[0], 4'd1, 4'd2);
            expect_val($sformatf("scrub_b%0d_busy", k), 2, 32'd1);
            tick();
        end
        reset = 1'b1;
        expect_reads("rst_mid", 32'd0, 32'd0, 1'b1);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive(k[0], 4'(1 + (k % 11)), 32'h6B000000 | k, ~k[0], k[0], 4'(1 + (k % 11)), 4'd5);
            expect_reads($sformatf("scrub_c%0d", k), 32'd0, 32'd0, (k < 20));
            tick();
        end
        for (int r = 1; r <= 11; r += 2) begin
            drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'(r), 4'(r + 1));
            expect_reads($sformatf("noise_r%0d", r), 32'd0, 32'd0, 1'b0);
            tick();
        end
        $display("restart scrub and write-during-scrub done");

        // ---- basic write/read ----
        drive(1'b0, 4'd5, 32'h12345678, 1'b1, 1'b0, 4'd0, 4'd0);
        expect_reads("wr_r5", 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd5, 4'd0);
        expect_reads("rd_r5_r0", 32'h12345678, 32'd0, 1'b0);
        tick();
        $display("basic write/read done");

        // ---- bypass ----
        drive(1'b0, 4'd7, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd7, 4'd7);
        expect_reads("byp_r7", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        tick();
        drive(1'b1, 4'd12, 32'h0C0C0C0C, 1'b1, 1'b0, 4'd12, 4'd12);
        expect_reads("byp_sup_r12", 32'h0C0C0C0C, 32'h0C0C0C0C, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd12, 4'd7);
        expect_reads("usr_r12", 32'd0, 32'hA5A5A5A5, 1'b0);
        tick();
        drive(1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 4'd12, 4'd5);
        expect_reads("sup_r12", 32'h0C0C0C0C, 32'h12345678, 1'b0);
        tick();
        // user-bank write via we2 while reading it in user mode: bypass
        drive(1'b0, 4'd15, 32'h0000F00D, 1'b0, 1'b1, 4'd15, 4'd3);
        expect_reads("byp_we2_r15", 32'h0000F00D, 32'd0, 1'b0);
        tick();
        $display("bypass done");

        // ---- banking ----
        drive(1'b1, 4'd13, 32'h00001111, 1'b1, 1'b0, 4'd0, 4'd0);
        expect_reads("wr_sup_r13", 32'd0, 32'd0, 1'b0);
        tick();
        // we2 targets user r13; a supervisor read of r13 must not bypass it
        drive(1'b1, 4'd13, 32'h00002222, 1'b0, 1'b1, 4'd13, 4'd15);
        expect_reads("wr_usr_r13", 32'h00001111, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 4'd13, 4'd13);
        expect_reads("sup_r13", 32'h00001111, 32'h00001111, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd13, 4'd15);
        expect_reads("usr_r13", 32'h00002222, 32'h0000F00D, 1'b0);
        tick();
        drive(1'b1, 4'd4, 32'h44444444, 1'b1, 1'b0, 4'd0, 4'd0);
        expect_reads("wr_sup_r4", 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd4, 4'd4);
        expect_reads("usr_r4", 32'h44444444, 32'h44444444, 1'b0);
        tick();
        drive(1'b0, 4'd4, 32'h40404040, 1'b1, 1'b0, 4'd0, 4'd0);
        expect_reads("wr_usr_r4", 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 4'd4, 4'd4);
        expect_reads("sup_r4", 32'h40404040, 32'h40404040, 1'b0);
        tick();
        $display("banking done");

        // ---- dual enable conflict ----
        drive(1'b1, 4'd14, 32'h0000CAFE, 1'b1, 1'b1, 4'd0, 4'd0);
        expect_reads("dual_wr", 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 32'd0, 1'b0, 1'b0, 4'd14, 4'd14);
        expect_reads("dual_sup_r14", 32'h0000CAFE, 32'h0000CAFE, 1'b0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd14, 4'd14);
        expect_reads("dual_usr_r14", 32'd0, 32'd0, 1'b0);
        tick();
        $display("dual enable done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
